a2d_spi_resp: RTL and testbench

A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

---
 rtl/a2d_spi_resp.sv | 181 ++++++++++++++++++
 tb/tb_a2d_spi_resp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/a2d_spi_resp.sv
// SPI slave that receives a 16-bit channel command and returns the 12-bit conversion
// value that was present on chnnl_val when the frame started.
module a2d_spi_resp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic [2:0]  chnnl_req,
  input  logic [11:0] chnnl_val,
  output logic [15:0] rx_cmd,
  output logic        frm_done,
  output logic        frm_err
);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;

  logic        ss_meta_r, ss_sync_r, ss_hist_r;
  logic        sclk_meta_r, sclk_sync_r, sclk_hist_r;
  logic        mosi_meta_r, mosi_sync_r, mosi_hist_r;

  logic        ss_fall_s, ss_rise_s, sclk_rise_s, sclk_fall_s;

  logic [15:0] tx_r, tx_nxt_s;
  logic [15:0] rx_r, rx_nxt_s;
  logic [4:0]  cnt_r, cnt_nxt_s;
  logic [1:0]  arm_cnt_r, arm_cnt_nxt_s;
  logic [15:0] rx_cmd_r, rx_cmd_nxt_s;
  logic [2:0]  req_r, req_nxt_s;
  logic        miso_r, miso_nxt_s;
  logic        done_r, done_nxt_s;
  logic        err_r, err_nxt_s;

  // Two-flop synchronizers plus one history stage per SPI pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_meta_r   <= 1'b1;
      ss_sync_r   <= 1'b1;
      ss_hist_r   <= 1'b1;
      sclk_meta_r <= 1'b1;
      sclk_sync_r <= 1'b1;
      sclk_hist_r <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      mosi_hist_r <= 1'b0;
    end else begin
      ss_meta_r   <= SS_n;
      ss_sync_r   <= ss_meta_r;
      ss_hist_r   <= ss_sync_r;
      sclk_meta_r <= SCLK;
      sclk_sync_r <= sclk_meta_r;
      sclk_hist_r <= sclk_sync_r;
      mosi_meta_r <= MOSI;
      mosi_sync_r <= mosi_meta_r;
      mosi_hist_r <= mosi_sync_r;
    end
  end

  assign ss_fall_s   =  ss_hist_r   & ~ss_sync_r;
  assign ss_rise_s   = ~ss_hist_r   &  ss_sync_r;
  assign sclk_rise_s = ~sclk_hist_r &  sclk_sync_r;
  assign sclk_fall_s =  sclk_hist_r & ~sclk_sync_r;

  // Next-state and datapath decode for the frame FSM
  always_comb begin
    state_nxt_s   = state_r;
    tx_nxt_s      = tx_r;
    rx_nxt_s      = rx_r;
    cnt_nxt_s     = cnt_r;
    arm_cnt_nxt_s = arm_cnt_r;
    rx_cmd_nxt_s  = rx_cmd_r;
    req_nxt_s     = req_r;
    done_nxt_s    = 1'b0;
    err_nxt_s     = 1'b0;

    case (state_r)
      ARM: begin
        // Synchronizer stages reset high, so wait until they hold real pin samples
        if (arm_cnt_r != 2'd3) begin
          arm_cnt_nxt_s = arm_cnt_r + 2'd1;
        end else if (ss_sync_r && ss_hist_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ARM;
        end
      end

      IDLE: begin
        if (ss_fall_s) begin
          tx_nxt_s    = {4'h0, chnnl_val};
          rx_nxt_s    = 16'h0000;
          cnt_nxt_s   = 5'd0;
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      SHIFT: begin
        if (ss_rise_s) begin
          state_nxt_s = CHECK;
        end else if (sclk_rise_s) begin
          rx_nxt_s = {rx_r[14:0], mosi_sync_r};
          if (cnt_r != 5'd17) begin
            cnt_nxt_s = cnt_r + 5'd1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end else if (sclk_fall_s && (cnt_r != 5'd0)) begin
          // The leading fall before the first rise must keep bit 15 on MISO
          tx_nxt_s = {tx_r[14:0], 1'b0};
        end else begin
          state_nxt_s = SHIFT;
        end
      end

      CHECK: begin
        if (cnt_r == 5'd16) begin
          rx_cmd_nxt_s = rx_r;
          req_nxt_s    = rx_r[13:11];
          done_nxt_s   = 1'b1;
        end else begin
          err_nxt_s    = 1'b1;
        end
        state_nxt_s = IDLE;
      end

      default: begin
        state_nxt_s = ARM;
      end
    endcase

    if ((state_nxt_s == SHIFT) || (state_nxt_s == CHECK)) begin
      miso_nxt_s = tx_nxt_s[15];
    end else begin
      miso_nxt_s = 1'b0;
    end
  end

  // FSM state, shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ARM;
      tx_r      <= 16'h0000;
      rx_r      <= 16'h0000;
      cnt_r     <= 5'd0;
      arm_cnt_r <= 2'd0;
      rx_cmd_r  <= 16'h0000;
      req_r     <= 3'b000;
      miso_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      tx_r      <= tx_nxt_s;
      rx_r      <= rx_nxt_s;
      cnt_r     <= cnt_nxt_s;
      arm_cnt_r <= arm_cnt_nxt_s;
      rx_cmd_r  <= rx_cmd_nxt_s;
      req_r     <= req_nxt_s;
      miso_r    <= miso_nxt_s;
      done_r    <= done_nxt_s;
      err_r     <= err_nxt_s;
    end
  end

  assign MISO      = miso_r;
  assign chnnl_req = req_r;
  assign rx_cmd    = rx_cmd_r;
  assign frm_done  = done_r;
  assign frm_err   = err_r;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: a bit-banged SPI master (SCLK idle high, 32 clk period)
// drives frames and checks readback, pulses, latency and register updates.
module tb_a2d_spi_resp;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [2:0]  chnnl_req;
  logic [11:0] chnnl_val;
  logic [15:0] rx_cmd;
  logic        frm_done;
  logic        frm_err;

  int          total;
  int          passed;
  int          done_cnt;
  int          err_cnt;
  int          both_cnt;
  int          lat;
  int          miso_ones;
  int          done0;
  int          err0;
  logic [15:0] rd;

  a2d_spi_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .chnnl_req (chnnl_req),
    .chnnl_val (chnnl_val),
    .rx_cmd    (rx_cmd),
    .frm_done  (frm_done),
    .frm_err   (frm_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Count high cycles of each pulse output, and cycles where both are high
  always @(negedge clk) begin
    if (frm_done === 1'b1) done_cnt++;
    if (frm_err === 1'b1) err_cnt++;
    if ((frm_done === 1'b1) && (frm_err === 1'b1)) both_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Send n bits of cmd starting at bit position 'first' (MSB first, zeros past bit 15)
  task automatic spi_bits(input logic [15:0] cmd, input int first, input int n);
    logic [15:0] sh;
    sh = cmd << first;
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      MOSI = sh[15];
      sh   = {sh[14:0], 1'b0};
      tick(16);
      rd = {rd[14:0], MISO};
      if (MISO !== 1'b0) miso_ones++;
      SCLK = 1'b1;
      tick(16);
    end
  endtask

  task automatic release_watch();
    lat  = 0;
    SS_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if ((frm_done === 1'b1) && (lat == 0)) lat = k;
    end
    tick(24);
  endtask

  task automatic frame(input logic [15:0] cmd, input int n);
    done0     = done_cnt;
    err0      = err_cnt;
    rd        = 16'h0000;
    miso_ones = 0;
    SS_n      = 1'b0;
    tick(16);
    spi_bits(cmd, 0, n);
    tick(8);
    release_watch();
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    both_cnt  = 0;
    rst_n     = 1'b0;
    SS_n      = 1'b1;
    SCLK      = 1'b1;
    MOSI      = 1'b0;
    chnnl_val = 12'h123;
    tick(3);
    chk("rst_miso",   32'(MISO),      32'h0);
    chk("rst_req",    32'(chnnl_req), 32'h0);
    chk("rst_rx_cmd", 32'(rx_cmd),    32'h0);
    chk("rst_done",   32'(frm_done),  32'h0);
    chk("rst_err",    32'(frm_err),   32'h0);
    rst_n = 1'b1;
    tick(10);

    // Frame 1: command 0x2800 selects channel 5; reply carries 0x123
    frame(16'h2800, 16);
    chk("f1_read",    32'(rd),                 32'h0123);
    chk("f1_done",    32'(done_cnt - done0),   32'h1);
    chk("f1_err",     32'(err_cnt - err0),     32'h0);
    chk("f1_latency", 32'(lat),                32'h4);
    chk("f1_req",     32'(chnnl_req),          32'h5);
    chk("f1_rx_cmd",  32'(rx_cmd),             32'h2800);
    chk("f1_miso_idle", 32'(MISO),             32'h0);

    // Frame 2: command 0x3800 selects channel 7; reply carries 0xA5C
    chnnl_val = 12'hA5C;
    frame(16'h3800, 16);
    chk("f2_read",    32'(rd),                 32'h0A5C);
    chk("f2_done",    32'(done_cnt - done0),   32'h1);
    chk("f2_req",     32'(chnnl_req),          32'h7);
    chk("f2_rx_cmd",  32'(rx_cmd),             32'h3800);

    // Short frame: 8 bits of 0x0777 reply read back, then error
    chnnl_val = 12'h777;
    frame(16'h1000, 8);
    chk("short_read",   32'(rd),               32'h0007);
    chk("short_err",    32'(err_cnt - err0),   32'h1);
    chk("short_done",   32'(done_cnt - done0), 32'h0);
    chk("short_req",    32'(chnnl_req),        32'h7);
    chk("short_rx_cmd", 32'(rx_cmd),           32'h3800);

    // Long frame: 17 clocks, 17th read bit is the shifted-in zero
    frame(16'h1000, 17);
    chk("long_read",    32'(rd),               32'h0EEE);
    chk("long_err",     32'(err_cnt - err0),   32'h1);
    chk("long_done",    32'(done_cnt - done0), 32'h0);
    chk("long_req",     32'(chnnl_req),        32'h7);
    chk("long_rx_cmd",  32'(rx_cmd),           32'h3800);

    // Reset after 6 bits; reply 0x0F5A has bit 10 set, so MISO is high at that point
    chnnl_val = 12'hF5A;
    rd        = 16'h0000;
    SS_n      = 1'b0;
    tick(16);
    spi_bits(16'h2800, 0, 6);
    chk("mid_miso_pre", 32'(MISO), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_miso_rst", 32'(MISO), 32'h0);
    tick(2);
    rst_n     = 1'b1;
    done0     = done_cnt;
    err0      = err_cnt;
    miso_ones = 0;
    spi_bits(16'h2800, 6, 10);
    tick(8);
    release_watch();
    chk("mid_miso_rest", 32'(miso_ones),         32'h0);
    chk("mid_done",      32'(done_cnt - done0),  32'h0);
    chk("mid_err",       32'(err_cnt - err0),    32'h0);
    chk("mid_miso_idle", 32'(MISO),              32'h0);

    frame(16'h1000, 16);
    chk("post_done",    32'(done_cnt - done0), 32'h1);
    chk("post_req",     32'(chnnl_req),        32'h2);
    chk("post_rx_cmd",  32'(rx_cmd),           32'h1000);

    // SCLK activity with SS_n high must be ignored
    done0     = done_cnt;
    err0      = err_cnt;
    miso_ones = 0;
    spi_bits(16'hFFFF, 0, 16);
    tick(16);
    chk("ssh_done",    32'(done_cnt - done0), 32'h0);
    chk("ssh_err",     32'(err_cnt - err0),   32'h0);
    chk("ssh_miso",    32'(miso_ones),        32'h0);
    chk("ssh_req",     32'(chnnl_req),        32'h2);
    chk("ssh_rx_cmd",  32'(rx_cmd),           32'h1000);

    chk("never_both",  32'(both_cnt),         32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
